// File: rtl/vga_scan_if.sv
// Pixel-FIFO read side and VGA output bundle for vga_scan.
interface vga_scan_if;
    localparam int unsigned PIX_W = 16;

    logic             fifo_empty;
    logic [PIX_W-1:0] fifo_data;
    logic             fifo_read;
    logic             trigger;
    logic             hsync;
    logic             vsync;
    logic [4:0]       red;
    logic [5:0]       green;
    logic [4:0]       blue;
    logic             underflow;

    modport master (
        output fifo_empty, fifo_data,
        input  fifo_read, trigger, hsync, vsync, red, green, blue, underflow
    );

    modport slave (
        input  fifo_empty, fifo_data,
        output fifo_read, trigger, hsync, vsync, red, green, blue, underflow
    );
endinterface

// File: rtl/vga_scan.sv
// VGA raster generator: free-running h/v counters, one-deep pixel pipeline fed
// from a FIFO, sync generation, frame trigger and sticky underflow flag.
module vga_scan #(
    parameter int unsigned H_VIS     = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VIS     = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter int unsigned TRIG_LINE = 520
) (
    input  logic        clk,
    input  logic        rst_n,
    vga_scan_if.slave   vga
);
    localparam int unsigned CNT_W    = 10;
    localparam int unsigned HT       = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned VT       = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_FIRST = H_VIS + H_FP;
    localparam int unsigned HS_LAST  = H_VIS + H_FP + H_SYNC - 1;
    localparam int unsigned VS_FIRST = V_VIS + V_FP;
    localparam int unsigned VS_LAST  = V_VIS + V_FP + V_SYNC - 1;

    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic             active_q, active_d;
    logic             got_q, got_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             trigger_q, trigger_d;
    logic             underflow_q, underflow_d;
    logic             active_c;
    logic             fifo_read_c;
    logic             pix_ok_c;

    // Stage 0: raster position, visibility and pop decision
    always_comb begin
        hcnt_d = hcnt_q + CNT_W'(1);
        vcnt_d = vcnt_q;
        if (hcnt_q == CNT_W'(HT - 1)) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == CNT_W'(VT - 1)) ? '0 : vcnt_q + CNT_W'(1);
        end
        active_c    = (hcnt_q < CNT_W'(H_VIS)) && (vcnt_q < CNT_W'(V_VIS));
        // (0,0) is visible, so the pop must be gated while reset holds the counters there
        fifo_read_c = rst_n && active_c && !vga.fifo_empty;
    end

    // Stage 1 next values, all decoded from the stage-0 position
    always_comb begin
        active_d    = active_c;
        got_d       = fifo_read_c;
        hsync_d     = !((hcnt_q >= CNT_W'(HS_FIRST)) && (hcnt_q <= CNT_W'(HS_LAST)));
        vsync_d     = !((vcnt_q >= CNT_W'(VS_FIRST)) && (vcnt_q <= CNT_W'(VS_LAST)));
        trigger_d   = (hcnt_q == '0) && (vcnt_q == CNT_W'(TRIG_LINE));
        underflow_d = underflow_q;
        if (active_c && vga.fifo_empty) begin
            underflow_d = 1'b1;
        end else if (trigger_d) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            active_q    <= 1'b0;
            got_q       <= 1'b0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            trigger_q   <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            active_q    <= active_d;
            got_q       <= got_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            trigger_q   <= trigger_d;
            underflow_q <= underflow_d;
        end
    end

    // FIFO read data arrives in stage 1, so colour is muxed straight from it
    assign pix_ok_c      = active_q && got_q;
    assign vga.fifo_read = fifo_read_c;
    assign vga.trigger   = trigger_q;
    assign vga.hsync     = hsync_q;
    assign vga.vsync     = vsync_q;
    assign vga.underflow = underflow_q;
    assign vga.red       = pix_ok_c ? vga.fifo_data[15:11] : 5'd0;
    assign vga.green     = pix_ok_c ? vga.fifo_data[10:5]  : 6'd0;
    assign vga.blue      = pix_ok_c ? vga.fifo_data[4:0]   : 5'd0;
endmodule

// File: tb/tb_vga_scan.sv
// Randomised bench for vga_scan: a reduced-size raster checked cycle by cycle
// against a position-based reference model, plus a full-size sync timing instance.
module tb_vga_scan;
    localparam int H_VIS = 16, H_FP = 2, H_SYNC = 4, H_BP = 3;
    localparam int V_VIS = 8,  V_FP = 1, V_SYNC = 2, V_BP = 2;
    localparam int TRIG  = 11;
    localparam int HT    = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int VT    = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FR    = HT * VT;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_big_n;
    always #5 clk = ~clk;

    vga_scan_if bus ();
    vga_scan_if big ();

    vga_scan #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .TRIG_LINE(TRIG)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (bus)
    );

    vga_scan dut_big (
        .clk   (clk),
        .rst_n (rst_big_n),
        .vga   (big)
    );

    // FIFO model: returns 0,1,2,... one cycle after each pop
    logic [15:0] fdata = 16'd0;
    int unsigned word  = 0;
    assign bus.fifo_data = fdata;
    always @(posedge clk) begin
        if (bus.fifo_read === 1'b1) begin
            fdata <= 16'(word);
            word  <= word + 1;
        end
    end
    assign big.fifo_data  = 16'd0;
    assign big.fifo_empty = 1'b0;

    int errors = 0;
    int checks = 0;
    bit big_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int hpos(input int idx);
        return idx % HT;
    endfunction

    function automatic int vpos(input int idx);
        return (idx / HT) % VT;
    endfunction

    function automatic bit vis(input int idx);
        return hpos(idx) < H_VIS && vpos(idx) < V_VIS;
    endfunction

    // Reference model state: k = clock edges since reset release
    int k;
    bit pv, pp, exp_uf;
    int pw, pops;

    task automatic model_reset();
        k = 0; pv = 0; pp = 0; pw = 0; exp_uf = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rd"},  32'(bus.fifo_read), 0);
        chk({tag, "_hs"},  32'(bus.hsync), 1);
        chk({tag, "_vs"},  32'(bus.vsync), 1);
        chk({tag, "_trg"}, 32'(bus.trigger), 0);
        chk({tag, "_uf"},  32'(bus.underflow), 0);
        chk({tag, "_rgb"}, 32'({bus.red, bus.green, bus.blue}), 0);
    endtask

    // One raster clock; mode 0 full, 1 line-5 gap, 2 random, 3 toggle
    task automatic cycle(input int mode);
        bit e, rd;
        int h0, v0, h1, v1;
        h0 = hpos(k);
        v0 = vpos(k);
        case (mode)
            1:       e = (k < FR) && v0 == 5 && h0 >= 10 && h0 <= 13;
            2:       e = ($urandom % 4) == 0;
            3:       e = k[0];
            default: e = 1'b0;
        endcase
        bus.fifo_empty = e;
        #1;
        rd = vis(k) && !e;
        chk("fifo_read", 32'(bus.fifo_read), 32'(rd));
        chk("underflow", 32'(bus.underflow), 32'(exp_uf));
        if (k == 0) begin
            chk("hsync0", 32'(bus.hsync), 1);
            chk("vsync0", 32'(bus.vsync), 1);
            chk("trig0",  32'(bus.trigger), 0);
            chk("rgb0",   32'({bus.red, bus.green, bus.blue}), 0);
        end else begin
            h1 = hpos(k - 1);
            v1 = vpos(k - 1);
            chk("hsync",   32'(bus.hsync), 32'(!(h1 >= H_VIS + H_FP && h1 < H_VIS + H_FP + H_SYNC)));
            chk("vsync",   32'(bus.vsync), 32'(!(v1 >= V_VIS + V_FP && v1 < V_VIS + V_FP + V_SYNC)));
            chk("trigger", 32'(bus.trigger), 32'(h1 == 0 && v1 == TRIG));
            chk("rgb",     32'({bus.red, bus.green, bus.blue}), (pv && pp) ? 32'(16'(pw)) : 0);
        end
        if (vis(k) && e) exp_uf = 1'b1;
        else if (h0 == 0 && v0 == TRIG) exp_uf = 1'b0;
        pv = vis(k);
        pp = rd;
        pw = pops;
        if (rd) pops++;
        @(posedge clk);
        k++;
        @(negedge clk);
    endtask

    task automatic mid_reset();
        int unsigned w0;
        bus.fifo_empty = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        w0 = word;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            chk("rst_no_read", 32'(bus.fifo_read), 0);
        end
        chk("rst_no_pop", w0, word);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.fifo_empty = 1'b0;
        pops = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        rst_n = 1'b1;
        repeat (FR) cycle(1);
        repeat (FR) cycle(0);
        repeat (2 * FR) cycle(2);
        repeat (FR) cycle(3);
        for (int i = 0; i < FR; i++) begin
            if (vpos(k) == 6 && hpos(k) == 7) break;
            cycle(3);
        end
        chk("pre_rst_uf", 32'(bus.underflow), 1);
        mid_reset();
        repeat (2 * FR) cycle(0);
        for (int i = 0; i < 4000 && !big_done; i++) @(negedge clk);
        chk("big_done", 32'(big_done), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Full-size instance: first hsync low 657 clocks after release, 96 wide, 800 period
    initial begin
        int n, w, p;
        rst_big_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_big_n = 1'b1;
        n = 0;
        while (n < 2000) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (big.hsync == 1'b0) break;
        end
        chk("big_hs_start", n, 657);
        w = 0;
        while (w < 2000 && big.hsync == 1'b0) begin
            @(posedge clk); w++;
            @(negedge clk);
        end
        chk("big_hs_width", w, 96);
        p = w;
        while (p < 2000 && big.hsync == 1'b1) begin
            @(posedge clk); p++;
            @(negedge clk);
        end
        chk("big_hs_period", p, 800);
        chk("big_vsync", 32'(big.vsync), 1);
        big_done = 1'b1;
    end
endmodule

// File: doc/vga_scan.md
VGA_SCAN -- requirements
Module: vga_scan

Interface
REQ-001 Parameters: H_VIS 640, H_FP 16, H_SYNC 96, H_BP 48, V_VIS 480, V_FP 10, V_SYNC 2, V_BP 33, TRIG_LINE 520.
- H_* are horizontal visible/front-porch/sync/back-porch widths in clocks.
- V_* are the vertical equivalents in lines.
- TRIG_LINE is the line at which the frame trigger fires.
REQ-002 clk  input  1  pixel clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 fifo_empty  input  1  pixel FIFO has no data.
REQ-005 fifo_data  input  16  FIFO read data (RGB565), valid the cycle after fifo_read.
REQ-006 fifo_read  output  1  FIFO pop strobe.
REQ-007 trigger  output  1  one-clock start-of-frame pulse to the line drawer.
REQ-008 hsync  output  1  horizontal sync, active-low.
REQ-009 vsync  output  1  vertical sync, active-low.
REQ-010 red  output  5  pixel red.
REQ-011 green  output  6  pixel green.
REQ-012 blue  output  5  pixel blue.
REQ-013 underflow  output  1  sticky flag: a visible pixel was needed while the FIFO was empty.

Function
REQ-014 Counters:
- hcnt (10 bit) counts 0..HT-1, where HT = H_VIS+H_FP+H_SYNC+H_BP = 800.
- vcnt (10 bit) counts 0..VT-1, where VT = 525.
- vcnt increments only when hcnt wraps from HT-1 to 0.
- vcnt wraps from VT-1 to 0 at the same edge.
REQ-015 Stage-0 visible: active = (hcnt < H_VIS) && (vcnt < V_VIS).
REQ-016 fifo_read = active && !fifo_empty, combinational from registered counters and fifo_empty; exactly one pop per visible pixel when data is present.
REQ-017 Stage-1 registers; all outputs below are delayed exactly one clock from the stage-0 counter values:
- active_d <= active.
- got_d <= fifo_read.
- hsync <= !(hcnt in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1]), i.e. low for hcnt 656..751.
- vsync <= !(vcnt in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1]), i.e. low for vcnt 490..491.
REQ-018 Colour outputs:
- When active_d && got_d: {red,green,blue} = fifo_data[15:11], fifo_data[10:5], fifo_data[4:0].
- Otherwise all colour outputs are 0 (blanking, or black for an underflowed pixel).
REQ-019 Underflow:
- Set underflow when active && fifo_empty at stage 0.
- A missing pixel is skipped, not delayed: the counters never stall, and later pixels keep their screen position.
REQ-020 trigger:
- Registered; high for exactly one clock when hcnt == 0 && vcnt == TRIG_LINE.
- Asserted in the same cycle the stage-1 registers reflect that position.
REQ-021 Clearing underflow: it clears on the cycle trigger is asserted.
- If a set condition occurs in the same cycle, set wins.
- No set condition can occur in that cycle, because TRIG_LINE >= V_VIS.
REQ-022 The FIFO is never popped outside visible area; data present during blanking stays in the FIFO.
REQ-023 Frame period is exactly HT*VT = 420000 clocks; hsync period 800 clocks; no dependency on FIFO state.

Reset
REQ-024 While rst_n is low, asynchronously:
- hcnt = 0, vcnt = 0.
- All stage-1 registers are 0; hsync = 1, vsync = 1.
- trigger = 0, fifo_read = 0, colour outputs = 0, underflow = 0.
REQ-025 After rst_n deasserts, counting starts at (0,0) on the first rising clk edge. trigger first fires when vcnt reaches TRIG_LINE, about 416000 clocks after reset, not at frame 0.
REQ-026 Reset asserted mid-line or mid-frame:
- Immediately forces the REQ-024 values.
- Drops fifo_read with no extra pop.
- The FIFO itself is not flushed by this block.

Verification
REQ-027 Free-run, FIFO always full (fifo_empty=0):
- hsync low exactly 96 clocks starting at hcnt 656 + 1 clock of latency.
- vsync low for 2 lines (490-491).
- Frame period 420000 clocks.
- 307200 pops per frame.
REQ-028 Data path: FIFO model returns incrementing values 0x0000, 0x0001, ...
- First visible pixel of the frame outputs red=0, green=0, blue=0.
- Pixel n outputs {red,green,blue} = n[15:0].
- Colour outputs are 0 during every blank clock.
REQ-029 Underflow: hold fifo_empty=1 for pixels 100..103 of line 5.
- fifo_read stays low for those 4 clocks.
- Those 4 outputs are black.
- underflow goes 1 and stays 1.
- Pixel 104 shows the next FIFO word.
- underflow returns to 0 on the next trigger.
REQ-030 trigger: exactly one 1-clock pulse per frame, at the output cycle for hcnt=0, vcnt=520, and never during visible area.
REQ-031 Mid-frame reset: assert rst_n=0 at line 200, pixel 300, for 3 clocks.
- All outputs take their reset values immediately, without waiting for a clk edge.
- After release, the next hsync low starts 656+1 clocks later.
- No fifo_read occurs while in reset.
REQ-032 Throttled FIFO: fifo_empty toggles every clock during a visible line.
- Pops occur only on non-empty cycles.
- Underflow is flagged.
- Sync timing is unchanged versus REQ-027.
